// File: rtl/aud_pkg.sv
// Shared types and widths for the audio recorder capture path.
package aud_pkg;

  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned LEN_W     = ADDR_W + 1;
  localparam int unsigned BIT_CNT_W = $clog2(SAMPLE_W);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLrc,
    StCapture,
    StStore,
    StPaused
  } rec_state_t;

endpackage

// File: rtl/i2s_rx_shift.sv
// MSB-first serial-to-parallel shifter with a bit counter for one I2S channel word.
module i2s_rx_shift
  import aud_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_shift,
  input  logic                i_data,
  output logic [SAMPLE_W-1:0] o_word,
  output logic                o_done
);

  logic [SAMPLE_W-1:0]  word_q;
  logic [BIT_CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_shift) begin
      word_q <= {word_q[SAMPLE_W-2:0], i_data};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign o_word = word_q;
  // High while the final bit of the word is being shifted in.
  assign o_done = (cnt_q == '1);

endmodule

// File: rtl/aud_recorder.sv
// I2S left-channel capture into SRAM with start/pause/stop control.
// Optional elapsed-seconds timer enabled by defining AUD_REC_TIMER_EN.
module aud_recorder
  import aud_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAX_ADDR    = 20'hFFFFF,
  parameter int unsigned       SAMPLE_RATE = 32000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_lrc,
  input  logic                i_data,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  output logic [ADDR_W-1:0]   o_address,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_write,
  output logic [LEN_W-1:0]    o_length,
  output logic                o_full,
  output logic                o_recording,
  output logic [7:0]          o_rec_sec
);

  rec_state_t          state_q, state_d;
  logic                lrc_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                full_q, full_d;
  logic                pend_q, pend_d;
  logic                sh_clear, sh_shift, sh_done;
  logic [SAMPLE_W-1:0] sh_word;
  logic                fresh_start, store;

  i2s_rx_shift u_shift (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (sh_clear),
    .i_shift (sh_shift),
    .i_data  (i_data),
    .o_word  (sh_word),
    .o_done  (sh_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      lrc_q   <= 1'b1;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lrc_q   <= i_lrc;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    data_d      = data_q;
    full_d      = full_q;
    pend_d      = pend_q;
    sh_clear    = 1'b0;
    sh_shift    = 1'b0;
    fresh_start = 1'b0;
    store       = 1'b0;
    unique case (state_q)
      StIdle: begin
        pend_d = 1'b0;
        // Any simultaneous stop or pause outranks the start.
        if (i_start && !i_stop && !i_pause) begin
          addr_d      = '0;
          len_d       = '0;
          full_d      = 1'b0;
          fresh_start = 1'b1;
          state_d     = StWaitLrc;
        end
      end
      StWaitLrc: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if (i_pause) begin
          state_d = StPaused;
        end else if (lrc_q && !i_lrc) begin
          // Falling LRC edge is the one-bit delay slot; data starts next cycle.
          sh_clear = 1'b1;
          state_d  = StCapture;
        end
      end
      StCapture: begin
        if (i_stop) begin
          pend_d  = 1'b0;
          state_d = StIdle;
        end else begin
          sh_shift = 1'b1;
          if (i_pause) pend_d = 1'b1;
          if (sh_done) state_d = StStore;
        end
      end
      StStore: begin
        store  = 1'b1;
        data_d = sh_word;
        len_d  = len_q + 1'b1;
        pend_d = 1'b0;
        if (addr_q == MAX_ADDR) begin
          full_d  = 1'b1;
          state_d = StIdle;
        end else begin
          addr_d = addr_q + 1'b1;
          if (i_stop) begin
            state_d = StIdle;
          end else if (pend_q || i_pause) begin
            state_d = StPaused;
          end else begin
            state_d = StWaitLrc;
          end
        end
      end
      StPaused: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if (i_start && !i_pause) begin
          state_d = StWaitLrc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_address   = addr_q;
  assign o_length    = len_q;
  assign o_full      = full_q;
  assign o_write     = (state_q == StStore);
  // The fresh word is presented during the strobe, then held in data_q.
  assign o_data      = (state_q == StStore) ? sh_word : data_q;
  assign o_recording = (state_q == StWaitLrc) || (state_q == StCapture) ||
                       (state_q == StStore);

`ifdef AUD_REC_TIMER_EN
  logic [31:0] tick_cnt_q;
  logic [7:0]  sec_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt_q <= '0;
      sec_q      <= '0;
    end else if (fresh_start) begin
      tick_cnt_q <= '0;
      sec_q      <= '0;
    end else if (store) begin
      if (tick_cnt_q == SAMPLE_RATE - 1) begin
        tick_cnt_q <= '0;
        if (sec_q != 8'hFF) sec_q <= sec_q + 1'b1;
      end else begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
    end
  end

  assign o_rec_sec = sec_q;
`else
  logic unused_timer;
  assign unused_timer = ^{SAMPLE_RATE, fresh_start, store};
  assign o_rec_sec    = '0;
`endif

endmodule
